mod_addsub_ctrl: RTL
====================

// Module: mod_addsub_ctrl
// PURPOSE
// Modular add/subtract sequencer for the Montgomery datapath. Computes (A+B) mod M or (A-B) mod M
// for WIDTH-bit operands by acting as initiator of the multi-precision adder's start/done handshake:
// one adder pass for the raw sum/difference, plus a conditional second pass for the modular correction.
// Sits between the top-level controller and the single shared mpadder instance.
// PARAMETERS
// WIDTH  1027  operand/modulus width in bits; adder result port is WIDTH+1 bits
// PORTS
// clk          in   1        rising-edge clock
// reset        in   1        asynchronous, active-high reset
// start        in   1        request pulse; sampled only in IDLE
// subtract     in   1        0: (A+B) mod M, 1: (A-B) mod M; captured with start
// in_a         in   WIDTH    operand A; precondition A < M
// in_b         in   WIDTH    operand B; precondition B < M
// modulus      in   WIDTH    M; precondition M < 2^(WIDTH-1)
// result       out  WIDTH    modular result; valid while done=1, held until next start
// done         out  1        one-cycle completion pulse
// busy         out  1        high from the cycle after an accepted start through the done cycle
// add_start    out  1        one-cycle start pulse to the adder
// add_subtract out  1        adder mode for the current pass
// add_in_a     out  WIDTH    adder operand A; held stable from add_start until add_done
// add_in_b     out  WIDTH    adder operand B; held stable from add_start until add_done
// add_result   in   WIDTH+1  adder result; bit WIDTH = carry-out (add) / borrow (subtract)
// add_done     in   1        adder completion; add_result valid in the same cycle
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; result, add_in_a, add_in_b=0; done, busy, add_start, add_subtract=0.
// - Outputs driven from registers only; no combinational path from inputs to outputs.
// - Internal registers: operand copies ra, rb, rm, rsub; temporary tmp[WIDTH-1:0].
// - FSM states: IDLE -> REQ1 -> WAIT1 -> (REQ2 -> WAIT2 ->) FIN -> IDLE.
// - IDLE:  if start=1, capture in_a, in_b, modulus and subtract into ra, rb, rm, rsub; go to REQ1.
//          Otherwise stay. A stray add_done in IDLE is ignored.
// - REQ1:  add_start=1 for exactly one cycle; add_in_a=ra, add_in_b=rb, add_subtract=rsub; go to WAIT1.
// - WAIT1: wait for add_done, holding operands. On add_done, tmp<=add_result[WIDTH-1:0], then:
//          add mode:                   go to REQ2 (pass 2 = tmp - rm)
//          sub mode, add_result[WIDTH]=0: result<=add_result[WIDTH-1:0]; go to FIN (no correction)
//          sub mode, add_result[WIDTH]=1: go to REQ2 (pass 2 = tmp + rm)
// - REQ2:  add_start=1 for one cycle; add_in_a=tmp, add_in_b=rm, add_subtract=~rsub; go to WAIT2.
// - WAIT2: on add_done:
//          add mode: result <= add_result[WIDTH]=0 ? add_result[WIDTH-1:0] : tmp
//                    (borrow on tmp-M means sum < M, so keep the sum)
//          sub mode: result <= add_result[WIDTH-1:0]  (wraps mod 2^WIDTH; the carry-out is discarded)
//          Then go to FIN.
// - FIN:   done=1 for exactly one cycle; go to IDLE. busy=0 on the following cycle.
// - Latency with a 1-cycle adder (start accepted in cycle N):
//          two-pass: add_start in N+1 and N+3; done in N+5.
//          one-pass (sub, no borrow): done in N+3.
//          Any adder latency >= 1 is tolerated; there is no timeout.
// - start while busy: ignored; the operation in flight and its result are unaffected.
// - A start sampled in the same cycle that FIN drives done=1 is ignored, because the FSM is not yet in IDLE.
// - Width rule: the preconditions keep A+B < 2^WIDTH, so the pass-1 add carry-out is always 0 and is ignored.
// - Precondition violations produce a result of A+B (or A-B) mod 2^WIDTH with no correction guarantee.
//   No error flag is raised.
// - Reset asserted mid-operation aborts immediately: no done pulse, and add_start deasserts asynchronously.
// TESTING
// All scenarios use WIDTH=1027 and a behavioural mpadder model with configurable latency (1 and 4 cycles).
// T1 add, latency 1: A=5, B=7, M=11 -> result=1; done 5 cycles after start; exactly 2 add_start pulses.
// T2 add, no wrap:   A=3, B=4, M=11 -> result=7 (second pass borrows, so the sum is kept).
// T3 sub, no wrap:   A=9, B=4, M=11 -> result=5; done 3 cycles after start; exactly 1 add_start pulse.
// T4 sub, wrap:      A=4, B=9, M=11 -> result=6; second pass has add_subtract=0, add_in_b=11.
// T5 wide add:       M=2^1026-1, A=B=M-1 -> result=M-2; repeat with adder latency 4 -> same result;
//                    add_in_a and add_in_b stay stable between each add_start and its add_done.
// T6 control:        start re-pulsed during WAIT1 -> ignored, single done; reset asserted in WAIT2 ->
//                    done, busy and add_start = 0 immediately; a fresh op afterwards
//                    (A=1, B=1, M=11) -> result=2.

Source files
------------

// File: rtl/mod_addsub_ctrl_if.sv
// Interfaces for the modular add/subtract sequencer.
//
// mod_addsub_req_if : request side, from the top-level controller.
//   master = controller, slave = sequencer.
//   start, subtract, in_a, in_b, modulus  -> sequencer
//   result, done, busy                    <- sequencer
//
// mod_addsub_add_if : adder side, towards the shared multi-precision adder.
//   master = sequencer (initiator), slave = adder.
//   add_start, add_subtract, add_in_a, add_in_b -> adder
//   add_result (WIDTH+1 bits, MSB = carry/borrow), add_done <- adder

interface mod_addsub_req_if #(
  parameter int WIDTH = 1027
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, subtract, in_a, in_b, modulus,
    input  result, done, busy
  );

  modport slave (
    input  start, subtract, in_a, in_b, modulus,
    output result, done, busy
  );
endinterface

interface mod_addsub_add_if #(
  parameter int WIDTH = 1027
);
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport master (
    output add_start, add_subtract, add_in_a, add_in_b,
    input  add_result, add_done
  );

  modport slave (
    input  add_start, add_subtract, add_in_a, add_in_b,
    output add_result, add_done
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer for the Montgomery datapath.
// Computes (A+B) mod M or (A-B) mod M by driving the shared multi-precision
// adder through one raw pass plus an optional correction pass.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   req    mod_addsub_req_if.slave  : start/subtract/in_a/in_b/modulus in,
//                                     result/done/busy out
//   add    mod_addsub_add_if.master : add_start/add_subtract/add_in_a/add_in_b out,
//                                     add_result/add_done in
// All outputs come straight from registers.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; operands captured on accept
// REQ1   | add_start high for pass 1 (A op B)
// WAIT1  | waiting for pass-1 add_done
// REQ2   | add_start high for correction pass (tmp -/+ M)
// WAIT2  | waiting for pass-2 add_done, selecting the final result
// FIN    | done pulse, then back to IDLE

module mod_addsub_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             reset,
  mod_addsub_req_if.slave  req,
  mod_addsub_add_if.master add
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ1  = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_REQ2  = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] rm_q, rm_d;
  logic             rsub_q, rsub_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             add_start_q, add_start_d;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;

  logic [WIDTH-1:0] sum_lo;
  logic             sum_msb;

  assign sum_lo  = add.add_result[WIDTH-1:0];
  assign sum_msb = add.add_result[WIDTH];

  always_comb begin
    state_d     = state_q;
    rm_d        = rm_q;
    rsub_d      = rsub_q;
    tmp_d       = tmp_q;
    result_d    = result_q;
    done_d      = done_q;
    busy_d      = busy_q;
    add_start_d = add_start_q;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;

    case (state_q)
      S_IDLE: begin
        if (req.start) begin
          // Pass-1 operands are loaded directly so add_start can be high
          // in the very next cycle; the adder registers double as A/B copies.
          rm_d        = req.modulus;
          rsub_d      = req.subtract;
          add_a_d     = req.in_a;
          add_b_d     = req.in_b;
          add_sub_d   = req.subtract;
          add_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_REQ1;
        end
      end

      S_REQ1: begin
        add_start_d = 1'b0;
        state_d     = S_WAIT1;
      end

      S_WAIT1: begin
        if (add.add_done) begin
          tmp_d = sum_lo;
          if (rsub_q && !sum_msb) begin
            // A >= B: the difference is already reduced.
            result_d = sum_lo;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            // Add: try tmp - M.  Sub with borrow: wrap back with tmp + M.
            add_a_d     = sum_lo;
            add_b_d     = rm_q;
            add_sub_d   = ~rsub_q;
            add_start_d = 1'b1;
            state_d     = S_REQ2;
          end
        end
      end

      S_REQ2: begin
        add_start_d = 1'b0;
        state_d     = S_WAIT2;
      end

      S_WAIT2: begin
        if (add.add_done) begin
          if (!rsub_q) begin
            // Borrow on tmp - M means the sum was already below M.
            result_d = sum_msb ? tmp_q : sum_lo;
          end else begin
            result_d = sum_lo;
          end
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        done_d      = 1'b0;
        busy_d      = 1'b0;
        add_start_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rm_q        <= '0;
      rsub_q      <= 1'b0;
      tmp_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rm_q        <= rm_d;
      rsub_q      <= rsub_d;
      tmp_q       <= tmp_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  assign req.result       = result_q;
  assign req.done         = done_q;
  assign req.busy         = busy_q;
  assign add.add_start    = add_start_q;
  assign add.add_subtract = add_sub_q;
  assign add.add_in_a     = add_a_q;
  assign add.add_in_b     = add_b_q;

endmodule
